// File: rtl/segre_if_prefetch.sv
// rtl/segre_if_prefetch.sv - instruction prefetch buffer with redirect flush
// One outstanding memory request feeds a FIFO of {pc, instr}; a redirect flushes and refetches.
module segre_if_prefetch #(
  parameter int                   ADDR_SIZE  = 32,
  parameter int                   WORD_SIZE  = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                             clk_i,
  input  logic                             rsn_i,
  output logic                             mem_req_o,
  output logic [ADDR_SIZE-1:0]             mem_addr_o,
  input  logic                             mem_ready_i,
  input  logic [WORD_SIZE-1:0]             mem_instr_i,
  input  logic                             redirect_i,
  input  logic [ADDR_SIZE-1:0]             redirect_pc_i,
  input  logic                             id_ready_i,
  output logic                             instr_valid_o,
  output logic [WORD_SIZE-1:0]             instr_o,
  output logic [ADDR_SIZE-1:0]             pc_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int            CW   = $clog2(FIFO_DEPTH + 1);
  localparam int            PW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t               state;
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] fetch_pc;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [ADDR_SIZE-1:0] redirect_tgt;
  logic [ADDR_SIZE-1:0] fetch_pc_inc;
  logic [ADDR_SIZE-1:0] pc_mem    [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] instr_mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        post_count;
  logic                 push;
  logic                 pop;

  assign redirect_tgt = redirect_pc_i & ~ADDR_SIZE'(3);
  assign fetch_pc_inc = fetch_pc + ADDR_SIZE'(4);
  assign push         = (state == REQ) && mem_ready_i && !redirect_i;
  assign pop          = (count != '0) && id_ready_i && !redirect_i;
  assign post_count   = count + CW'(push) - CW'(pop);

  // DROP waits out a response that a redirect made stale before reissuing.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) begin
            fetch_pc <= redirect_tgt;
            req_addr <= redirect_tgt;
            state    <= REQ;
            mem_req  <= 1'b1;
          end else if (count < FULL) begin
            req_addr <= fetch_pc;
            state    <= REQ;
            mem_req  <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_i && mem_ready_i) begin
            fetch_pc <= redirect_tgt;
            req_addr <= redirect_tgt;
          end else if (redirect_i) begin
            fetch_pc <= redirect_tgt;
            state    <= DROP;
          end else if (mem_ready_i) begin
            fetch_pc <= fetch_pc_inc;
            if (post_count < FULL) begin
              req_addr <= fetch_pc_inc;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (mem_ready_i) begin
            fetch_pc <= redirect_i ? redirect_tgt : fetch_pc;
            req_addr <= redirect_i ? redirect_tgt : fetch_pc;
            state    <= REQ;
          end else if (redirect_i) begin
            fetch_pc <= redirect_tgt;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= post_count;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_addr;
      instr_mem[wr_ptr] <= mem_instr_i;
    end
  end

  assign mem_req_o     = mem_req;
  assign mem_addr_o    = req_addr;
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr] : '0;
  assign fifo_count_o  = count;

endmodule

// File: tb/tb_segre_if_prefetch.sv
// tb/tb_segre_if_prefetch.sv - self-checking bench for segre_if_prefetch
// Directed vector table, reset corner sequence, then random traffic against a queue model.
module tb_segre_if_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rsn_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_instr_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_ready_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  segre_if_prefetch dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ready_i   (mem_ready_i),
    .mem_instr_i   (mem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fifo_count_o  (fifo_count_o)
  );

  // Instruction memory: a distinct word per address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A0F0F;
  endfunction

  assign mem_instr_i = mem_fn(mem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit er, input logic [31:0] ea,
                           input bit ev, input logic [31:0] ep, input int ec);
    chk({tag, " mem_req"}, 32'(mem_req_o), 32'(er));
    if (er) chk({tag, " mem_addr"}, mem_addr_o, ea);
    chk({tag, " valid"}, 32'(instr_valid_o), 32'(ev));
    chk({tag, " pc"}, pc_o, ev ? ep : 32'h0);
    chk({tag, " instr"}, instr_o, ev ? mem_fn(ep) : NOP);
    chk({tag, " count"}, 32'(fifo_count_o), 32'(ec));
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit idr);
    mem_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    id_ready_i    = idr;
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          idr;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] ep;
    int          ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rdy, input bit redir, input logic [31:0] rpc, input bit idr,
                             input bit er, input logic [31:0] ea, input bit ev,
                             input logic [31:0] ep, input int ec);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.rpc = rpc; r.idr = idr;
    r.er = er; r.ea = ea; r.ev = ev; r.ep = ep; r.ec = ec;
    return r;
  endfunction

  // Reference model: a queue of fetched entries plus the one outstanding request.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_stale;

  task automatic model_reset();
    mq.delete();
    m_fetch = 32'h0;
    m_addr  = 32'h0;
    m_busy  = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit idr);
    logic [31:0] tgt;
    int          n0;
    tgt = {rpc[31:2], 2'b00};
    n0  = mq.size();
    if (redir) begin
      mq.delete();
      m_fetch = tgt;
      if (!m_busy || rdy) begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = tgt;
      end else begin
        m_stale = 1'b1;
      end
    end else begin
      if (n0 > 0 && idr) void'(mq.pop_front());
      if (!m_busy) begin
        if (n0 < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_fetch;
        end
      end else if (rdy) begin
        if (!m_stale) begin
          mq.push_back('{m_addr, mem_fn(m_addr)});
          m_fetch = m_fetch + 32'd4;
        end
        m_stale = 1'b0;
        if (mq.size() < DEPTH) m_addr = m_fetch;
        else m_busy = 1'b0;
      end
    end
  endtask

  initial begin
    bit          rdy;
    bit          redir;
    bit          idr;
    logic [31:0] rpc;
    entry_t      head;

    // rdy, redir, rpc, idr | mem_req, mem_addr, valid, pc, count
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        1));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h8,        1, 32'h4,        1));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'hC,        1, 32'h8,        1));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h10,       1, 32'hC,        1));
    tbl.push_back(v(0, 0, 32'h0,        1, 1, 32'h10,       0, 32'h0,        0));
    tbl.push_back(v(0, 1, 32'h103,      1, 1, 32'h10,       0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,        1, 1, 32'h10,       0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,        1, 1, 32'h10,       0, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,        0, 1, 32'h104,      1, 32'h100,      1));
    tbl.push_back(v(1, 0, 32'h0,        0, 1, 32'h108,      1, 32'h100,      2));
    tbl.push_back(v(1, 1, 32'h200,      1, 1, 32'h200,      0, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,        0, 1, 32'h204,      1, 32'h200,      1));
    tbl.push_back(v(1, 0, 32'h0,        0, 1, 32'h208,      1, 32'h200,      2));
    tbl.push_back(v(1, 0, 32'h0,        0, 1, 32'h20C,      1, 32'h200,      3));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200,      4));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200,      4));
    tbl.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h204,      3));
    tbl.push_back(v(0, 0, 32'h0,        0, 1, 32'h210,      1, 32'h204,      3));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h204,      4));
    tbl.push_back(v(0, 1, 32'hFFFFFFFE, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h0,        1, 32'hFFFFFFFC, 1));
    tbl.push_back(v(1, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        1));

    @(posedge clk_i);
    #1;
    check_all("reset", 0, 32'h0, 0, 32'h0, 0);
    rsn_i = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rdy, tbl[i].redir, tbl[i].rpc, tbl[i].idr);
      check_all($sformatf("vec%0d", i), tbl[i].er, tbl[i].ea, tbl[i].ev, tbl[i].ep, tbl[i].ec);
    end

    // Reset while a request is outstanding, with a stray response right after release.
    cycle(0, 0, 32'h0, 0);
    check_all("pending", 1, 32'h4, 1, 32'h0, 1);
    #2;
    rsn_i = 1'b0;
    #1;
    check_all("async_rst", 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    cycle(1, 0, 32'h0, 1);
    check_all("post_rst0", 1, 32'h0, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 1);
    check_all("post_rst1", 1, 32'h4, 1, 32'h0, 1);

    rsn_i = 1'b0;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(3) != 0);
      redir = ($urandom_range(15) == 0);
      idr   = ($urandom_range(2) != 0);
      case ($urandom_range(2))
        0:       rpc = $urandom_range(255);
        1:       rpc = 32'hFFFFFFF0 | $urandom_range(15);
        default: rpc = $urandom;
      endcase
      cycle(rdy, redir, rpc, idr);
      model_step(rdy, redir, rpc, idr);
      if (mq.size() > 0) head = mq[0];
      else head = '{32'h0, NOP};
      check_all($sformatf("rnd%0d", i), m_busy, m_addr, mq.size() > 0, head.pc, mq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
